// File: rtl/udp_checksum_engine_if.sv
// Beat stream and result bundle for the UDP checksum engine.
// master drives the datagram; slave is the engine.
interface udp_checksum_engine_if #(
  parameter int DATA_W = 32
);
  logic              i_start;
  logic              i_mode;
  logic [15:0]       i_seed;
  logic              i_valid;
  logic [DATA_W-1:0] i_data;
  logic [DATA_W/8-1:0] i_keep;
  logic              i_last;
  logic              o_ready;
  logic              o_busy;
  logic              o_done;
  logic [15:0]       o_checksum;
  logic              o_checksum_valid;
  logic              o_err;

  modport master (
    output i_start, i_mode, i_seed,
    output i_valid, i_data, i_keep, i_last,
    input  o_ready, o_busy, o_done,
    input  o_checksum, o_checksum_valid, o_err
  );

  modport slave (
    input  i_start, i_mode, i_seed,
    input  i_valid, i_data, i_keep, i_last,
    output o_ready, o_busy, o_done,
    output o_checksum, o_checksum_valid, o_err
  );
endinterface

// File: rtl/udp_checksum_engine.sv
// Streaming ones'-complement checksum over byte-masked beats,
// seeded by a pseudo-header sum; generate or verify mode.
module udp_checksum_engine #(
  parameter int DATA_W    = 32,
  parameter int MAX_BEATS = 1024
) (
  input logic i_clk,
  input logic i_rst,
  udp_checksum_engine_if.slave bus
);
  localparam int LANES = DATA_W / 16;
  localparam int NB    = DATA_W / 8;
  localparam int CW    = $clog2(MAX_BEATS + 1);

  typedef enum logic [1:0] {
    IDLE, ACCUM, FOLD, DONE
  } state_t;

  state_t state, state_nxt;

  logic [31:0]       acc;
  logic [CW-1:0]     cnt;
  logic [CW-1:0]     cnt_inc;
  logic              mode_q;
  logic              err_q;
  logic [15:0]       chk_q;
  logic              cv_q;
  logic              err_out;
  logic              accept;
  logic [DATA_W-1:0] masked;
  logic [31:0]       beat_sum;
  logic [16:0]       s17;
  logic [15:0]       f;
  logic [15:0]       inv;
  logic [15:0]       gen;

  always_comb begin
    masked = '0;
    for (int b = 0; b < NB; b++) begin
      masked[b*8 +: 8] = bus.i_keep[b] ?
        bus.i_data[b*8 +: 8] : 8'h00;
    end
    beat_sum = '0;
    for (int l = 0; l < LANES; l++) begin
      beat_sum = beat_sum + {16'h0, masked[l*16 +: 16]};
    end
  end

  // end-around carry: two steps always suffice for 32 bits
  always_comb begin
    s17 = {1'b0, acc[15:0]} + {1'b0, acc[31:16]};
    f   = s17[15:0] + {15'h0, s17[16]};
    inv = ~f;
    gen = (inv == 16'h0000) ? 16'hFFFF : inv;
  end

  assign accept  = (state == ACCUM) && bus.i_valid;
  assign cnt_inc = cnt + CW'(1);

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (bus.i_start) state_nxt = ACCUM;
      ACCUM: begin
        if (accept && (bus.i_last ||
            cnt_inc == CW'(MAX_BEATS)))
          state_nxt = FOLD;
      end
      FOLD:  state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state   <= IDLE;
      acc     <= '0;
      cnt     <= '0;
      mode_q  <= 1'b0;
      err_q   <= 1'b0;
      chk_q   <= 16'h0000;
      cv_q    <= 1'b0;
      err_out <= 1'b0;
    end else begin
      state <= state_nxt;
      unique case (state)
        IDLE: begin
          if (bus.i_start) begin
            acc    <= {16'h0, bus.i_seed};
            cnt    <= '0;
            mode_q <= bus.i_mode;
            err_q  <= 1'b0;
          end
        end
        ACCUM: begin
          if (accept) begin
            acc <= acc + beat_sum;
            cnt <= cnt_inc;
            if (!bus.i_last &&
                cnt_inc == CW'(MAX_BEATS))
              err_q <= 1'b1;
          end
        end
        FOLD: begin
          chk_q   <= mode_q ? f : gen;
          cv_q    <= mode_q && !err_q &&
                     (f == 16'hFFFF);
          err_out <= err_q;
        end
        default: ;
      endcase
    end
  end

  assign bus.o_ready          = (state == ACCUM);
  assign bus.o_busy           = (state != IDLE);
  assign bus.o_done           = (state == DONE);
  assign bus.o_checksum       = chk_q;
  assign bus.o_checksum_valid = cv_q;
  assign bus.o_err            = err_out;
endmodule

// File: tb/tb_udp_checksum_engine.sv
// Directed vectors for the UDP checksum engine, plus abort,
// mid-datagram reset, idle-gap and back-to-back sequences.
module tb_udp_checksum_engine;
  logic i_clk = 1'b0;
  logic i_rst = 1'b0;

  always #5 i_clk = ~i_clk;

  udp_checksum_engine_if #(.DATA_W(32)) bus ();

  udp_checksum_engine #(
    .DATA_W(32),
    .MAX_BEATS(4)
  ) dut (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .bus(bus)
  );

  typedef struct {
    string       name;
    logic        mode;
    logic [15:0] seed;
    int          nb;
    logic [31:0] d0;
    logic [3:0]  k0;
    logic [31:0] d1;
    logic [3:0]  k1;
    logic        gap;
    logic [15:0] chk;
    logic        cv;
  } vec_t;

  vec_t vecs [9];
  int n_run  = 0;
  int n_fail = 0;

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h",
               nm, act, exp);
    end
  endtask

  task automatic start_dg(input logic m,
                          input logic [15:0] s);
    bus.i_start = 1'b1;
    bus.i_mode  = m;
    bus.i_seed  = s;
    @(posedge i_clk); #1;
    bus.i_start = 1'b0;
  endtask

  task automatic send_beat(input string nm,
                           input logic [31:0] d,
                           input logic [3:0] k,
                           input logic l);
    bus.i_valid = 1'b1;
    bus.i_data  = d;
    bus.i_keep  = k;
    bus.i_last  = l;
    @(negedge i_clk);
    check({nm, "_ready"}, 32'(bus.o_ready), 32'd1);
    @(posedge i_clk); #1;
    bus.i_valid = 1'b0;
    bus.i_last  = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    int  waitc;
    bit  got;
    start_dg(v.mode, v.seed);
    check({v.name, "_busy"}, 32'(bus.o_busy), 32'd1);
    for (int i = 0; i < v.nb; i++) begin
      if (i == 1 && v.gap) begin
        // idle cycle with a stray start that must be ignored
        bus.i_start = 1'b1;
        bus.i_seed  = 16'hFFFF;
        bus.i_mode  = ~v.mode;
        @(posedge i_clk); #1;
        bus.i_start = 1'b0;
      end
      send_beat(v.name, (i == 0) ? v.d0 : v.d1,
                (i == 0) ? v.k0 : v.k1, (i == v.nb - 1));
    end
    check({v.name, "_fold_rdy"}, 32'(bus.o_ready), 32'd0);
    check({v.name, "_fold_done"}, 32'(bus.o_done), 32'd0);
    waitc = 0;
    got   = 1'b0;
    while (!got && waitc < 8) begin
      @(posedge i_clk); #1;
      waitc++;
      got = bus.o_done;
    end
    check({v.name, "_latency"}, 32'(waitc), 32'd1);
    check({v.name, "_chk"}, 32'(bus.o_checksum), 32'(v.chk));
    check({v.name, "_cv"}, 32'(bus.o_checksum_valid),
          32'(v.cv));
    check({v.name, "_err"}, 32'(bus.o_err), 32'd0);
    @(posedge i_clk); #1;
    check({v.name, "_done_low"}, 32'(bus.o_done), 32'd0);
    check({v.name, "_hold"}, 32'(bus.o_checksum), 32'(v.chk));
  endtask

  initial begin
    bit saw_done;
    vecs[0] = '{"gen_basic", 1'b0, 16'h0000, 1,
                32'h0001F203, 4'hF, 32'h0, 4'h0, 1'b0,
                16'h0DFB, 1'b0};
    vecs[1] = '{"ver_ok", 1'b1, 16'h0000, 2,
                32'h0001F203, 4'hF, 32'h0DFB0000, 4'hF, 1'b0,
                16'hFFFF, 1'b1};
    vecs[2] = '{"ver_bad", 1'b1, 16'h0000, 2,
                32'h0001F203, 4'hF, 32'h0DFA0000, 4'hF, 1'b0,
                16'hFFFE, 1'b0};
    vecs[3] = '{"odd_len", 1'b0, 16'h0000, 1,
                32'hFFFFAB12, 4'hE, 32'h0, 4'h0, 1'b0,
                16'h54FF, 1'b0};
    vecs[4] = '{"zero_rule", 1'b0, 16'h0000, 1,
                32'hFFFF0000, 4'hF, 32'h0, 4'h0, 1'b0,
                16'hFFFF, 1'b0};
    vecs[5] = '{"seeded", 1'b0, 16'h1234, 1,
                32'h00010002, 4'hF, 32'h0, 4'h0, 1'b0,
                16'hEDC8, 1'b0};
    vecs[6] = '{"keep_gap", 1'b0, 16'h0000, 2,
                32'hAABBCCDD, 4'h5, 32'h00000001, 4'hF, 1'b1,
                16'hFE66, 1'b0};
    vecs[7] = '{"carry", 1'b0, 16'h8000, 1,
                32'h80008000, 4'hF, 32'h0, 4'h0, 1'b0,
                16'h7FFE, 1'b0};
    vecs[8] = '{"ver_carry", 1'b1, 16'hFFFF, 1,
                32'hFFFFFFFF, 4'hF, 32'h0, 4'h0, 1'b0,
                16'hFFFF, 1'b1};

    bus.i_start = 1'b0;
    bus.i_mode  = 1'b0;
    bus.i_seed  = 16'h0;
    bus.i_valid = 1'b0;
    bus.i_data  = 32'h0;
    bus.i_keep  = 4'h0;
    bus.i_last  = 1'b0;

    repeat (3) @(posedge i_clk);
    #1;
    check("rst_ready", 32'(bus.o_ready), 32'd0);
    check("rst_busy", 32'(bus.o_busy), 32'd0);
    check("rst_done", 32'(bus.o_done), 32'd0);
    check("rst_chk", 32'(bus.o_checksum), 32'd0);
    check("rst_cv", 32'(bus.o_checksum_valid), 32'd0);
    check("rst_err", 32'(bus.o_err), 32'd0);
    i_rst = 1'b1;
    @(posedge i_clk); #1;

    // back-to-back: each run starts the cycle after DONE
    foreach (vecs[i]) run_vec(vecs[i]);

    // beat-limit abort: 4 beats accepted, fifth refused
    start_dg(1'b0, 16'h0000);
    for (int i = 0; i < 5; i++) begin
      bus.i_valid = 1'b1;
      bus.i_data  = 32'h00010001;
      bus.i_keep  = 4'hF;
      bus.i_last  = 1'b0;
      @(negedge i_clk);
      check($sformatf("abort_ready%0d", i),
            32'(bus.o_ready), (i < 4) ? 32'd1 : 32'd0);
      @(posedge i_clk); #1;
    end
    bus.i_valid = 1'b0;
    check("abort_done", 32'(bus.o_done), 32'd1);
    check("abort_err", 32'(bus.o_err), 32'd1);
    check("abort_cv", 32'(bus.o_checksum_valid), 32'd0);
    check("abort_chk", 32'(bus.o_checksum), 32'hFFF7);
    @(posedge i_clk); #1;
    run_vec(vecs[0]);

    // reset mid-datagram
    start_dg(1'b0, 16'h4321);
    send_beat("mid_b0", 32'h12345678, 4'hF, 1'b0);
    send_beat("mid_b1", 32'h9ABCDEF0, 4'hF, 1'b0);
    i_rst = 1'b0;
    @(posedge i_clk); #1;
    i_rst = 1'b1;
    check("mid_ready", 32'(bus.o_ready), 32'd0);
    check("mid_busy", 32'(bus.o_busy), 32'd0);
    check("mid_chk", 32'(bus.o_checksum), 32'd0);
    check("mid_cv", 32'(bus.o_checksum_valid), 32'd0);
    check("mid_err", 32'(bus.o_err), 32'd0);
    saw_done = 1'b0;
    repeat (4) begin
      @(posedge i_clk); #1;
      saw_done = saw_done | bus.o_done;
    end
    check("mid_no_done", 32'(saw_done), 32'd0);
    run_vec(vecs[5]);
    run_vec(vecs[6]);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/udp_checksum_engine.md
# udp_checksum_engine

Streaming UDP/IP ones'-complement checksum engine, a parametrised successor to the single-word checksum verifier. It accepts a datagram as a sequence of `DATA_W`-bit beats with byte enables, seeded by a pseudo-header partial sum. It runs in either generate mode (emit the checksum field value) or verify mode (check the received checksum). It sits after the packet parser and in front of the RX accept/drop logic and TX header insertion.

## Interface
- `DATA_W`, 32: beat width in bits; multiple of 16, range 16–128.
- `MAX_BEATS`, 1024: beats allowed per datagram before abort; `MAX_BEATS*DATA_W/16` must be < 65536.
- `i_clk`  in  1  clock; all logic on rising edge.
- `i_rst`  in  1  reset, synchronous, active-low.
- `i_start`  in  1  pulse; begins a datagram and loads the seed. Sampled only in IDLE.
- `i_mode`  in  1  0 = generate, 1 = verify. Latched on accepted `i_start`.
- `i_seed`  in  16  pseudo-header partial sum. Latched on accepted `i_start`.
- `i_valid`  in  1  beat valid.
- `i_data`  in  DATA_W  beat data, network order; MSB byte is the first byte on the wire.
- `i_keep`  in  DATA_W/8  byte enables; bit `DATA_W/8-1` maps to the MSB byte.
- `i_last`  in  1  final beat of the datagram.
- `o_ready`  out  1  beat accept; a beat transfers when `i_valid && o_ready`.
- `o_busy`  out  1  high in every state except IDLE.
- `o_done`  out  1  one-cycle result pulse.
- `o_checksum`  out  16  generate: field value; verify: folded sum.
- `o_checksum_valid`  out  1  verify result, qualified by `o_done`.
- `o_err`  out  1  beat-limit abort, qualified by `o_done`.

## Operation
- FSM states: IDLE, ACCUM, FOLD, DONE.
  - IDLE: `i_start` → ACCUM. Accumulator ← `{16'h0, i_seed}`, beat counter ← 0, mode latched.
  - ACCUM: `o_ready` = 1. Each accepted beat adds its lanes to the accumulator and increments the beat counter. Accepted beat with `i_last` → FOLD. If an accepted beat without `i_last` brings the count to `MAX_BEATS` → FOLD with the error flag set.
  - FOLD: two-step end-around fold, `s = acc[15:0] + acc[31:16]`, then `f = s[15:0] + s[16]`. Result registered. → DONE.
  - DONE: `o_done` = 1 for one cycle, outputs presented. → IDLE.
- Lane sum per beat: masked data is `i_data` with bytes whose `i_keep` bit is 0 forced to 0. The beat sum is the zero-extended sum of the `DATA_W/16` 16-bit lanes of the masked data.
- Odd-length datagrams pad naturally, because the masked trailing low byte is 0.
- Accumulator is 32 bits. The `MAX_BEATS` bound guarantees no overflow, so no fold is needed during ACCUM.
- Generate mode:
  - `o_checksum = ~f`.
  - If `~f == 16'h0000`, `o_checksum = 16'hFFFF` (UDP zero rule).
  - `o_checksum_valid` = 0.
- Verify mode: the data includes the received checksum field. `o_checksum = f`; `o_checksum_valid = (f == 16'hFFFF)`.
- `o_err` = 1 only on a beat-limit abort. On abort, `o_checksum_valid` = 0 and `o_checksum` still reflects the partial sum.
- `i_start` outside IDLE is ignored. `i_valid` outside ACCUM is not accepted (`o_ready` = 0).
- `i_keep` is applied on every beat, not only the last one.

## Timing
- Reset values: `o_ready`, `o_busy`, `o_done`, `o_checksum_valid`, `o_err` = 0; `o_checksum` = 16'h0000; state = IDLE; accumulator and counter = 0.
- `i_start` at cycle T → `o_ready` high from T+1.
- Last beat accepted at cycle N → FOLD at N+1 → `o_done` at N+2. `o_ready` falls at N+1.
- `o_checksum`, `o_checksum_valid` and `o_err` hold their values after `o_done` until the next `o_done` or reset.
- Back-to-back: an `i_start` sampled in the cycle after DONE is accepted. Minimum datagram period is 4 cycles for a 1-beat datagram.
- Reset asserted mid-datagram: all state returns to IDLE on the next edge, no `o_done` is produced, and the partial sum is discarded.
- Idle cycles inside ACCUM (`i_valid` = 0) are allowed. They do not count toward `MAX_BEATS`.

## Test plan
- Generate, DATA_W=32, seed 0, one beat 32'h0001F203, keep 4'hF, last → `o_done` 2 cycles after the beat, `o_checksum` = 16'h0DFB.
- Verify, seed 0, beats 32'h0001F203 then 32'h0DFB0000 (last, keep 4'hF) → `o_checksum` = 16'hFFFF, `o_checksum_valid` = 1. The same stream with the second beat 32'h0DFA0000 → `o_checksum_valid` = 0.
- Odd length, generate, seed 0, beat 32'hFFFFAB12, keep 4'hE, last → masked sum 16'hAB00, `o_checksum` = 16'h54FF.
- Zero rule, generate, seed 16'h0000, beat 32'hFFFF0000, keep 4'hF, last → `~f` = 0, `o_checksum` = 16'hFFFF.
- Abort, MAX_BEATS=4, five valid beats with no `i_last` → 4 beats accepted, then `o_ready` = 0, `o_done` with `o_err` = 1 and `o_checksum_valid` = 0. A following `i_start` is accepted normally.
- Reset mid-datagram: `i_rst` low for 1 cycle after 2 beats → no `o_done`, all outputs at reset values. A new datagram then computes correctly, unaffected by the prior beats. Also cover `i_valid` gaps and back-to-back datagrams.
